// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch-stage control bundle between decode/exception logic and pc_unit
interface pc_unit_if;
  logic        stall;
  logic [25:0] Instr_D;
  logic [31:0] PC_D;
  logic [31:0] rs;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  NPCOp;
  logic        exc_req;
  logic [31:0] exc_pc;
  logic        exc_bd;
  logic        eret;
  logic [31:0] PC_F;
  logic [31:0] npc;
  logic [31:0] EPC;
  logic        exl;
  logic        flush_F;
  logic        bd_F;
  logic        misalign_F;
  modport master (
    output stall, Instr_D, PC_D, rs, A, B, NPCOp, exc_req, exc_pc, exc_bd, eret,
    input  PC_F, npc, EPC, exl, flush_F, bd_F, misalign_F
  );
  modport slave (
    input  stall, Instr_D, PC_D, rs, A, B, NPCOp, exc_req, exc_pc, exc_bd, eret,
    output PC_F, npc, EPC, exl, flush_F, bd_F, misalign_F
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: fetch PC, next-PC selection, branch/jump redirect; exception/eret logic enabled by PC_UNIT_EXC_EN
module pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_PC     = 32'h0000_4180,
  parameter int          DELAY_SLOT = 1
) (
  input logic clk,
  input logic reset,
  pc_unit_if.slave b
);
  logic [31:0] pc, t, bj_pc;
  logic taken, is_br, is_j, bj, exc_acc, eret_acc;
  assign t = b.PC_D + 32'd4 + {{14{b.Instr_D[15]}}, b.Instr_D[15:0], 2'b00};
  always_comb begin
    taken = 1'b0;
    case (b.NPCOp)
      4'd1: taken = b.A == b.B;
      4'd2: taken = !b.A[31];
      4'd3: taken = !b.A[31] && b.A != '0;
      4'd4: taken = b.A[31] || b.A == '0;
      4'd5: taken = b.A[31];
      4'd6: taken = b.A != b.B;
      default: taken = 1'b0;
    endcase
  end
  assign is_br = b.NPCOp >= 4'd1 && b.NPCOp <= 4'd6;
  assign is_j = b.NPCOp == 4'd7 || b.NPCOp == 4'd8;
  assign bj = taken || is_j;
  assign bj_pc = b.NPCOp == 4'd7 ? {b.PC_D[31:28], b.Instr_D, 2'b00} : b.NPCOp == 4'd8 ? b.rs : t;
`ifdef PC_UNIT_EXC_EN
  typedef enum logic {NORMAL, HANDLER} state_t;
  state_t state;
  logic [31:0] epc, epc_src;
  assign exc_acc = b.exc_req && state == NORMAL;
  assign eret_acc = b.eret && state == HANDLER;
  assign epc_src = b.exc_bd ? b.exc_pc - 32'd4 : b.exc_pc;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= NORMAL;
      epc <= '0;
    end else if (exc_acc) begin
      state <= HANDLER;
      epc <= epc_src & ~32'd3;
    end else if (eret_acc) begin
      state <= NORMAL;
    end
  assign b.EPC = epc;
  assign b.exl = state == HANDLER;
`else
  assign exc_acc = 1'b0;
  assign eret_acc = 1'b0;
  assign b.EPC = '0;
  assign b.exl = 1'b0;
`endif
  assign b.npc = exc_acc ? EXC_PC : eret_acc ? b.EPC : bj ? bj_pc : pc + 32'd4;
  // exception entry and eret must move the PC even when the pipeline is stalled
  always_ff @(posedge clk or posedge reset)
    if (reset) pc <= RESET_PC;
    else if (!b.stall || exc_acc || eret_acc) pc <= b.npc;
  assign b.PC_F = pc;
  assign b.misalign_F = |pc[1:0];
  assign b.flush_F = !reset && (exc_acc || eret_acc || (DELAY_SLOT == 0 && !b.stall && bj));
  assign b.bd_F = !reset && DELAY_SLOT != 0 && (is_br || is_j);
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed stimulus against a behavioural PC model, both delay-slot modes side by side
module tb_pc_unit;
  localparam logic [31:0] RST = 32'h0000_3000;
  localparam logic [31:0] EXC = 32'h0000_4180;
`ifdef PC_UNIT_EXC_EN
  localparam bit EXC_EN = 1'b1;
`else
  localparam bit EXC_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int errs = 0;
  pc_unit_if u1 ();
  pc_unit_if u0 ();
  pc_unit #(.DELAY_SLOT(1)) dut1 (.clk(clk), .reset(reset), .b(u1.slave));
  pc_unit #(.DELAY_SLOT(0)) dut0 (.clk(clk), .reset(reset), .b(u0.slave));
  assign u0.stall = u1.stall;
  assign u0.Instr_D = u1.Instr_D;
  assign u0.PC_D = u1.PC_D;
  assign u0.rs = u1.rs;
  assign u0.A = u1.A;
  assign u0.B = u1.B;
  assign u0.NPCOp = u1.NPCOp;
  assign u0.exc_req = u1.exc_req;
  assign u0.exc_pc = u1.exc_pc;
  assign u0.exc_bd = u1.exc_bd;
  assign u0.eret = u1.eret;
  always #5 clk = ~clk;

  logic [31:0] m_pc, m_epc, tgt, e_npc;
  logic m_exl, acc_exc, acc_eret, is_bj;

  function automatic logic br_taken(input logic [3:0] op, input logic [31:0] a, input logic [31:0] bb);
    int sa, sb;
    sa = a;
    sb = bb;
    case (op)
      4'd1: return sa == sb;
      4'd2: return sa >= 0;
      4'd3: return sa > 0;
      4'd4: return sa <= 0;
      4'd5: return sa < 0;
      4'd6: return sa != sb;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    acc_exc = EXC_EN && u1.exc_req && !m_exl;
    acc_eret = EXC_EN && u1.eret && m_exl && !acc_exc;
    is_bj = br_taken(u1.NPCOp, u1.A, u1.B) || u1.NPCOp == 4'd7 || u1.NPCOp == 4'd8;
    tgt = u1.NPCOp == 4'd7 ? {u1.PC_D[31:28], u1.Instr_D, 2'b00} :
          u1.NPCOp == 4'd8 ? u1.rs :
          u1.PC_D + 32'd4 + 32'(int'($signed(u1.Instr_D[15:0])) * 4);
    e_npc = acc_exc ? EXC : acc_eret ? m_epc : is_bj ? tgt : m_pc + 32'd4;
  end

  always @(posedge clk or posedge reset)
    if (reset) begin
      m_pc <= RST;
      m_epc <= '0;
      m_exl <= 1'b0;
    end else begin
      if (acc_exc || acc_eret || !u1.stall) m_pc <= e_npc;
      if (acc_exc) begin
        m_exl <= 1'b1;
        m_epc <= (u1.exc_bd ? u1.exc_pc - 32'd4 : u1.exc_pc) & ~32'd3;
      end else if (acc_eret) m_exl <= 1'b0;
    end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("PC_F", u1.PC_F, m_pc);
    chk("PC_F_ds0", u0.PC_F, m_pc);
    chk("EPC", u1.EPC, m_epc);
    chk("exl", 32'(u1.exl), 32'(m_exl));
    chk("misalign_F", 32'(u1.misalign_F), 32'(m_pc[1:0] != 2'b00));
    if (reset) begin
      chk("flush_rst", 32'(u1.flush_F), 0);
      chk("flush_rst_ds0", 32'(u0.flush_F), 0);
      chk("bd_rst", 32'(u1.bd_F), 0);
    end else begin
      chk("npc", u1.npc, e_npc);
      chk("npc_ds0", u0.npc, e_npc);
      chk("flush_F", 32'(u1.flush_F), 32'(acc_exc || acc_eret));
      chk("flush_F_ds0", 32'(u0.flush_F), 32'(acc_exc || acc_eret || (!u1.stall && is_bj)));
      chk("bd_F", 32'(u1.bd_F), 32'(u1.NPCOp >= 4'd1 && u1.NPCOp <= 4'd8));
      chk("bd_F_ds0", 32'(u0.bd_F), 0);
    end
  end

  task automatic apply(input logic [3:0] op, input logic [25:0] ins, input logic [31:0] pcd,
                       input logic [31:0] a, input logic [31:0] bb, input logic [31:0] r,
                       input logic st, input logic er, input logic [31:0] ep, input logic ebd,
                       input logic et);
    @(posedge clk);
    #1;
    u1.NPCOp = op;
    u1.Instr_D = ins;
    u1.PC_D = pcd;
    u1.A = a;
    u1.B = bb;
    u1.rs = r;
    u1.stall = st;
    u1.exc_req = er;
    u1.exc_pc = ep;
    u1.exc_bd = ebd;
    u1.eret = et;
    @(negedge clk);
  endtask

  initial begin
    u1.NPCOp = '0;
    u1.Instr_D = '0;
    u1.PC_D = '0;
    u1.A = '0;
    u1.B = '0;
    u1.rs = '0;
    u1.stall = 1'b0;
    u1.exc_req = 1'b0;
    u1.exc_pc = '0;
    u1.exc_bd = 1'b0;
    u1.eret = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk) chk("seq0", u1.PC_F, 32'h3000);
    @(negedge clk) chk("seq1", u1.PC_F, 32'h3004);
    @(negedge clk) chk("seq2", u1.PC_F, 32'h3008);
    apply(4'd1, 26'h000FFFF, 32'h3010, 32'd5, 32'd5, 0, 0, 0, 0, 0, 0);
    chk("beq_npc", u1.npc, 32'h3010);
    chk("beq_flush_ds1", 32'(u1.flush_F), 0);
    chk("beq_flush_ds0", 32'(u0.flush_F), 1);
    apply(4'd5, 26'h0000004, 32'h3010, 32'h8000_0000, 0, 0, 0, 0, 0, 0, 0);
    chk("beq_pc", u1.PC_F, 32'h3010);
    chk("bltz_npc", u1.npc, 32'h3024);
    apply(4'd3, 26'h0000040, 32'h3020, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("bgtz_npc", u1.npc, 32'h3028);
    apply(4'd1, 26'h000FFFF, 32'h3010, 32'd7, 32'd7, 0, 1, 0, 0, 0, 0);
    chk("stall_br_npc", u1.npc, 32'h3010);
    chk("stall_br_flush_ds0", 32'(u0.flush_F), 0);
    apply(4'd7, 26'h0000C40, 32'h3028, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("stall_hold", u1.PC_F, 32'h3028);
    chk("j_npc", u1.npc, 32'h3100);
    apply(4'd8, 26'h0, 32'h3100, 0, 0, 32'h3202, 0, 0, 0, 0, 0);
    chk("jr_npc", u1.npc, 32'h3202);
    apply(4'd9, 26'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("misalign", 32'(u1.misalign_F), 1);
    chk("op9_npc", u1.npc, 32'h3206);
    apply(4'd8, 26'h0, 0, 0, 0, 32'h3040, 0, 0, 0, 0, 0);
    apply(4'd0, 26'h0, 0, 0, 0, 0, 1, 1, 32'h3020, 1, 0);
    chk("exc_npc", u1.npc, EXC_EN ? 32'h4180 : 32'h3044);
    apply(4'd0, 26'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("exc_pc", u1.PC_F, EXC_EN ? 32'h4180 : 32'h3040);
    chk("exc_epc", u1.EPC, EXC_EN ? 32'h301C : 32'h0);
    chk("exc_exl", 32'(u1.exl), 32'(EXC_EN));
    apply(4'd0, 26'h0, 0, 0, 0, 0, 0, 1, 32'h5000, 0, 0);
    chk("exc_ignored_npc", u1.npc, EXC_EN ? 32'h4188 : 32'h3048);
    apply(4'd0, 26'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("eret_npc", u1.npc, EXC_EN ? 32'h301C : 32'h304C);
    apply(4'd0, 26'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("eret_pc", u1.PC_F, EXC_EN ? 32'h301C : 32'h304C);
    chk("eret_exl", 32'(u1.exl), 0);
    apply(4'd0, 26'h0, 0, 0, 0, 0, 0, 1, 32'h3030, 0, 1);
    chk("exc_eret_npc", u1.npc, EXC_EN ? 32'h4180 : 32'h3054);
    apply(4'd0, 26'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("exc_eret_exl", 32'(u1.exl), 32'(EXC_EN));
    apply(4'd0, 26'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    apply(4'd0, 26'h0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("eret_normal_flush", 32'(u1.flush_F), 0);
    apply(4'd1, 26'h0, 0, 0, 0, 0, 0, 1, 32'h3100, 0, 0);
    apply(4'd1, 26'h0, 0, 0, 0, 0, 0, 1, 32'h3100, 0, 0);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("rst_pc", u1.PC_F, 32'h3000);
    chk("rst_exl", 32'(u1.exl), 0);
    chk("rst_epc", u1.EPC, 0);
    chk("rst_flush", 32'(u1.flush_F), 0);
    chk("rst_bd", 32'(u1.bd_F), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    apply(4'd0, 26'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
